program_sequencer: RTL
======================

# program_sequencer

Parametrised fetch and run-control unit for the single-cycle CPU. It replaces the bare PC, the jump LUT and the hard-wired `done` compare. It accepts a four-phase `req`/`done` handshake from the host and starts the selected program. It then drives `prog_ctr` to the instruction ROM, applies absolute (LUT) or relative jumps requested by the control decoder, and stops on a halt instruction, end address or PC wrap, reporting a cycle count.

## Interface
- `D`, 10, program counter width
- `NPROG`, 4, number of selectable programs (power of two, ≥2)
- `STRIDE`, 256, start-address spacing; program k starts at k*STRIDE
- `END_ADDR`, 1023, PC value at which the run ends
- `LW`, 5, jump-LUT index width (2^LW entries)
- `OW`, 6, relative offset width, two's complement
- `CW`, 16, cycle-counter width

Ports:
- `clk`, in, 1, clock; all state updates on rising edge
- `reset`, in, 1, asynchronous, active-low reset
- `req`, in, 1, host start request (four-phase)
- `prog_sel`, in, $clog2(NPROG), program select, sampled with `req`
- `stall`, in, 1, hold PC this cycle
- `jump_en`, in, 1, take a jump this cycle
- `jump_rel`, in, 1, 1 = relative, 0 = absolute via LUT
- `jump_idx`, in, LW, LUT index for absolute jump
- `jump_off`, in, OW, signed offset for relative jump
- `halt_instr`, in, 1, decoder reports a halt opcode at current PC
- `prog_ctr`, out, D, instruction address
- `fetch_valid`, out, 1, `prog_ctr` holds a live instruction (RUN state)
- `busy`, out, 1, START or RUN
- `done`, out, 1, run complete, held until `req` low
- `wrap_err`, out, 1, run ended by PC wrap
- `cycles`, out, CW, RUN cycles of last/current run, saturating

## Operation
- States: IDLE, START, RUN, DONE. Reset → IDLE.
- IDLE: if `req`=1, latch `prog_sel`, clear `cycles` and `wrap_err`, go to START.
- START (1 cycle): `prog_ctr` ← `prog_sel`*STRIDE, truncated to D bits. Go to RUN.
- RUN: `fetch_valid`=1. Each cycle `cycles` increments, saturating at 2^CW−1, including stalled cycles. Priority per cycle:
  - `halt_instr` → DONE; PC holds.
  - else `prog_ctr`==END_ADDR and not `stall` → DONE.
  - else `stall` → hold PC; jump inputs ignored.
  - else `jump_en` & `jump_rel` → PC ← PC + sign_ext(`jump_off`), modulo 2^D.
  - else `jump_en` & !`jump_rel` → PC ← LUT[`jump_idx`].
  - else, PC == 2^D−1 → `wrap_err`=1, DONE; PC holds.
  - else PC ← PC+1.
- A relative jump whose result wraps modulo 2^D is legal and does not set `wrap_err`.
- DONE: `done`=1, PC and `cycles` hold. When `req`=0 → IDLE; `done` drops the next cycle.
- `req` is ignored in START/RUN. A run always completes.
- Jump LUT contents are fixed at elaboration. Entries beyond the defined list read 0.

## Timing
- Reset (async assert, sync-safe deassert): `prog_ctr`=0, `fetch_valid`=0, `busy`=0, `done`=0, `wrap_err`=0, `cycles`=0, state IDLE.
- Reset mid-run aborts immediately to IDLE with all outputs at reset values.
- `req` high at edge n (IDLE) → START at n+1 → start address on `prog_ctr` and `fetch_valid`=1 at n+2.
- Jump or increment takes effect one edge after it is sampled. The new `prog_ctr` is visible the following cycle with no bubble.
- Halt sampled at edge m → `done`=1 from m+1. The final `cycles` value includes the halt cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `seq_pkg` holds:
  - state enum `seq_state_t` {IDLE, START, RUN, DONE}
  - default parameter constants
  - the jump-target constant array.
- Sub-module `seq_jump_lut` (params D, LW): combinational index → target from the `seq_pkg` array.
- FSM, PC register and counter live in `program_sequencer`.

## Test plan
- Reset, `req`=1, `prog_sel`=2, no jumps → `prog_ctr` 512, 513, …. `halt_instr` at 515 → `done`=1 one cycle later, `cycles`=4. `req`=0 → `done`=0, state IDLE.
- At PC 300, relative jump with `jump_off`=−5 → next PC 295. With `jump_off`=+31 → PC 331. At PC 2, offset −5 → PC 1021, `wrap_err`=0.
- Absolute jump with `jump_idx`=3 → PC = table[3]. Out-of-range index → PC 0.
- `stall` held 3 cycles at PC 10 with `jump_en`=1 → PC stays 10, `cycles` advances by 3. Stall released with no jump → 11. Simultaneous `halt_instr` and `jump_en` → DONE, PC unchanged.
- Program 3 (start 768), END_ADDR=1023 → run ends at PC 1023, `wrap_err`=0. With END_ADDR set above 2^D−1 → PC reaches 1023, then `wrap_err`=1, DONE.
- `reset` asserted asynchronously mid-RUN at PC 600 → all outputs 0 immediately. `req` pulsing during RUN → no restart. CW=4 run of 20 cycles → `cycles`=15.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer.
// Holds the FSM state enum, default parameters and jump targets.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    DONE
  } seq_state_t;

  localparam int D_DEF        = 10;
  localparam int NPROG_DEF    = 4;
  localparam int STRIDE_DEF   = 256;
  localparam int END_ADDR_DEF = 1023;
  localparam int LW_DEF       = 5;
  localparam int OW_DEF       = 6;
  localparam int CW_DEF       = 16;

  // Defined jump targets; higher LUT indices read as zero.
  localparam int JT_N = 8;
  localparam int unsigned JUMP_TABLE [JT_N] = '{
    32'd100, 32'd200, 32'd37, 32'd640,
    32'd5,   32'd900, 32'd1000, 32'd77
  };

endpackage

// File: rtl/program_sequencer_if.sv
// Host/decoder/fetch bundle of the program sequencer.
// master drives requests and decode results; slave is the sequencer.
interface program_sequencer_if
  import seq_pkg::*;
#(
  parameter int D     = D_DEF,
  parameter int NPROG = NPROG_DEF,
  parameter int LW    = LW_DEF,
  parameter int OW    = OW_DEF,
  parameter int CW    = CW_DEF
);
  localparam int PSW = (NPROG > 1) ? $clog2(NPROG) : 1;

  logic           req;
  logic [PSW-1:0] prog_sel;
  logic           stall;
  logic           jump_en;
  logic           jump_rel;
  logic [LW-1:0]  jump_idx;
  logic [OW-1:0]  jump_off;
  logic           halt_instr;
  logic [D-1:0]   prog_ctr;
  logic           fetch_valid;
  logic           busy;
  logic           done;
  logic           wrap_err;
  logic [CW-1:0]  cycles;

  modport master (
    output req, prog_sel, stall,
    output jump_en, jump_rel,
    output jump_idx, jump_off, halt_instr,
    input  prog_ctr, fetch_valid, busy,
    input  done, wrap_err, cycles
  );

  modport slave (
    input  req, prog_sel, stall,
    input  jump_en, jump_rel,
    input  jump_idx, jump_off, halt_instr,
    output prog_ctr, fetch_valid, busy,
    output done, wrap_err, cycles
  );

endinterface

// File: rtl/seq_jump_lut.sv
// Absolute jump target lookup.
// Combinational index to target from the package table.
module seq_jump_lut
  import seq_pkg::*;
#(
  parameter int D  = D_DEF,
  parameter int LW = LW_DEF
) (
  input  logic [LW-1:0] idx,
  output logic [D-1:0]  target
);

  always_comb begin
    target = '0;
    for (int i = 0; i < JT_N; i++) begin
      if (32'(idx) == i) target = D'(JUMP_TABLE[i]);
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Fetch and run-control unit: host handshake, PC, jumps,
// halt/end/wrap detection and saturating run-cycle counter.
module program_sequencer
  import seq_pkg::*;
#(
  parameter int D        = D_DEF,
  parameter int NPROG    = NPROG_DEF,
  parameter int STRIDE   = STRIDE_DEF,
  parameter int END_ADDR = END_ADDR_DEF,
  parameter int LW       = LW_DEF,
  parameter int OW       = OW_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic clk,
  input  logic reset,
  program_sequencer_if.slave bus
);

  localparam int PSW = (NPROG > 1) ? $clog2(NPROG) : 1;

  seq_state_t     state_q, state_d;
  logic [PSW-1:0] sel_q, sel_d;
  logic [D-1:0]   pc_q, pc_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic           wrap_q, wrap_d;

  logic [D-1:0]   lut_tgt;
  logic [D-1:0]   off_ext;
  logic [D-1:0]   start_pc;
  logic           at_end;

  seq_jump_lut #(
    .D  (D),
    .LW (LW)
  ) u_lut (
    .idx    (bus.jump_idx),
    .target (lut_tgt)
  );

  assign off_ext  = D'($signed(bus.jump_off));
  assign start_pc = D'(32'(sel_q) * 32'(STRIDE));
  // END_ADDR may exceed the PC range; compare at 32 bits.
  assign at_end   = (32'(pc_q) == 32'(END_ADDR));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    wrap_d  = wrap_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          sel_d   = bus.prog_sel;
          cyc_d   = '0;
          wrap_d  = 1'b0;
          state_d = START;
        end
      end
      START: begin
        pc_d    = start_pc;
        state_d = RUN;
      end
      RUN: begin
        if (~&cyc_q) cyc_d = cyc_q + CW'(1);
        if (bus.halt_instr) begin
          state_d = DONE;
        end else if (at_end && !bus.stall) begin
          state_d = DONE;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.jump_en && bus.jump_rel) begin
          pc_d = pc_q + off_ext;
        end else if (bus.jump_en) begin
          pc_d = lut_tgt;
        end else if (&pc_q) begin
          wrap_d  = 1'b1;
          state_d = DONE;
        end else begin
          pc_d = pc_q + D'(1);
        end
      end
      DONE: begin
        if (!bus.req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      pc_q    <= '0;
      cyc_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.prog_ctr    = pc_q;
  assign bus.fetch_valid = (state_q == RUN);
  assign bus.busy        = (state_q == START) ||
                           (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.wrap_err    = wrap_q;
  assign bus.cycles      = cyc_q;

endmodule
